// File: rtl/clkdiv_pkg.sv
// Shared types for the programmable clock divider: FSM states, config record
// and the clamp that keeps every period at least one cycle high and one low.
package clkdiv_pkg;

    localparam int CLKDIV_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } clkdiv_state_e;

    typedef struct packed {
        logic [CLKDIV_CNT_W-1:0] div;
        logic [CLKDIV_CNT_W-1:0] high;
    } clkdiv_cfg_t;

    // The high-time limit is taken against the already-clamped divisor.
    function automatic clkdiv_cfg_t clkdiv_clamp(input logic [CLKDIV_CNT_W-1:0] div,
                                                 input logic [CLKDIV_CNT_W-1:0] high);
        clkdiv_cfg_t res;
        res.div  = (div < CLKDIV_CNT_W'(2)) ? CLKDIV_CNT_W'(2) : div;
        res.high = (high == '0) ? CLKDIV_CNT_W'(1) : high;
        if (res.high >= res.div) begin
            res.high = res.div - 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/clkdiv_if.sv
// Config handshake bundle for the clock divider: valid/ready plus the
// requested divisor and high time.
interface clkdiv_if
    import clkdiv_pkg::*;
#(
    parameter int CNT_W = CLKDIV_CNT_W
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_high;

    modport master (output cfg_valid, output cfg_div, output cfg_high, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_div, input cfg_high, output cfg_ready);
endinterface

// File: rtl/clkdiv_cfg_shadow.sv
// Depth-1 pending config slot: clamps on accept and holds the setting until
// the FSM signals a period boundary through apply.
module clkdiv_cfg_shadow
    import clkdiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    clkdiv_if.slave     cfg,
    input  logic        apply,
    output logic        pending,
    output clkdiv_cfg_t cfg_pend
);
    logic accept;

    assign accept        = cfg.cfg_valid & cfg.cfg_ready;
    assign cfg.cfg_ready = ~pending;

    // accept and apply are exclusive: apply needs a full slot, accept an empty one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= 1'b0;
            cfg_pend <= '0;
        end else if (accept) begin
            pending  <= 1'b1;
            cfg_pend <= clkdiv_clamp(CLKDIV_CNT_W'(cfg.cfg_div), CLKDIV_CNT_W'(cfg.cfg_high));
        end else if (apply) begin
            pending <= 1'b0;
        end
    end
endmodule

// File: rtl/clock_divider.sv
// Programmable clock divider: FSM, phase counter and registered clk_out/edge strobes.
// Defining CLKDIV_PERIOD_CNT_EN adds a free-running period_cnt output.
module clock_divider
    import clkdiv_pkg::*;
#(
    parameter int CNT_W        = CLKDIV_CNT_W,
    parameter int DEFAULT_DIV  = 4,
    parameter int DEFAULT_HIGH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    clkdiv_if.slave     cfg,
    output logic        clk_out,
    output logic        rise_tick,
    output logic        fall_tick,
    output logic        busy
`ifdef CLKDIV_PERIOD_CNT_EN
    ,
    output logic [31:0] period_cnt
`endif
);
    localparam clkdiv_cfg_t DEF_CFG =
        clkdiv_clamp(CLKDIV_CNT_W'(DEFAULT_DIV), CLKDIV_CNT_W'(DEFAULT_HIGH));

    clkdiv_state_e    state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    clkdiv_cfg_t      act_cfg, cfg_pend;
    logic             pending, apply, last, clk_out_n;

    clkdiv_cfg_shadow u_shadow (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg      (cfg),
        .apply    (apply),
        .pending  (pending),
        .cfg_pend (cfg_pend)
    );

    assign last = (cnt == CNT_W'(act_cfg.div - 1'b1));
    assign busy = (state != IDLE);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        clk_out_n = clk_out;
        apply     = 1'b0;
        case (state)
            IDLE: begin
                apply     = pending;
                cnt_n     = '0;
                clk_out_n = en;
                state_n   = en ? RUN : IDLE;
            end
            RUN, STOP: begin
                if (last) begin
                    // Period boundary: the only point where a new setting may land.
                    apply     = pending;
                    cnt_n     = '0;
                    clk_out_n = en;
                    state_n   = en ? RUN : IDLE;
                end else begin
                    cnt_n     = cnt + 1'b1;
                    clk_out_n = (CLKDIV_CNT_W'(cnt_n) < act_cfg.high);
                    state_n   = en ? RUN : STOP;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            act_cfg   <= DEF_CFG;
            clk_out   <= 1'b0;
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            if (apply) begin
                act_cfg <= cfg_pend;
            end
            clk_out   <= clk_out_n;
            rise_tick <= clk_out_n & ~clk_out;
            fall_tick <= ~clk_out_n & clk_out;
        end
    end

`ifdef CLKDIV_PERIOD_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + {31'd0, rise_tick};
        end
    end
`endif
endmodule

// File: tb/tb_clock_divider.sv
// Self-checking bench for clock_divider: hand tables, corner sequences and a
// queue-based period model under random stimulus.
module tb_clock_divider;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic clk_out, rise_tick, fall_tick, busy;
`ifdef CLKDIV_PERIOD_CNT_EN
    logic [31:0] period_cnt;
`endif

    always #20 clk = ~clk;

    clkdiv_if #(.CNT_W(16)) cfg_bus ();

    clock_divider #(.CNT_W(16), .DEFAULT_DIV(4), .DEFAULT_HIGH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg        (cfg_bus),
        .clk_out    (clk_out),
        .rise_tick  (rise_tick),
        .fall_tick  (fall_tick),
        .busy       (busy)
`ifdef CLKDIV_PERIOD_CNT_EN
        ,
        .period_cnt (period_cnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a period is a queue of H ones then N-H zeros.
    bit exp_q[$];
    int act_n, act_h, pend_n, pend_h;
    bit pend, m_clk, m_rise, m_fall, m_busy;

    typedef struct {
        logic        en;
        logic        valid;
        logic [15:0] div;
        logic [15:0] high;
        logic [4:0]  want;   // {clk_out, rise_tick, fall_tick, busy, cfg_ready}
    } vec_t;
    vec_t tbl[19];

    logic [5:0] pat6;
    logic [6:0] pat7;
    logic [7:0] pat8;

    function automatic logic [4:0] dut_vec();
        return {clk_out, rise_tick, fall_tick, busy, cfg_bus.cfg_ready};
    endfunction

    function automatic logic [4:0] model_vec();
        return {m_clk, m_rise, m_fall, m_busy, ~pend};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endtask

    task automatic model_reset();
        exp_q.delete();
        act_n  = 4;
        act_h  = 2;
        pend   = 1'b0;
        pend_n = 0;
        pend_h = 0;
        m_clk  = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_busy = 1'b0;
    endtask

    task automatic model_edge(input bit e, input bit v, input int d, input int h);
        bit prev;
        bit acc;
        int cn, ch;
        prev = m_clk;
        acc  = v && !pend;
        if (exp_q.size() == 0) begin
            if (pend) begin
                act_n = pend_n;
                act_h = pend_h;
                pend  = 1'b0;
            end
            if (e) begin
                for (int i = 0; i < act_n; i++) exp_q.push_back(i < act_h);
                m_clk  = exp_q.pop_front();
                m_busy = 1'b1;
            end else begin
                m_clk  = 1'b0;
                m_busy = 1'b0;
            end
        end else begin
            m_clk  = exp_q.pop_front();
            m_busy = 1'b1;
        end
        if (acc) begin
            cn = (d < 2) ? 2 : d;
            ch = (h == 0) ? 1 : h;
            if (ch >= cn) ch = cn - 1;
            pend   = 1'b1;
            pend_n = cn;
            pend_h = ch;
        end
        m_rise = m_clk && !prev;
        m_fall = !m_clk && prev;
    endtask

    task automatic step(input bit e, input bit v, input int d, input int h);
        en                = e;
        cfg_bus.cfg_valid = v;
        cfg_bus.cfg_div   = 16'(d);
        cfg_bus.cfg_high  = 16'(h);
        model_edge(e, v, d, h);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n             = 1'b0;
        en                = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_div   = '0;
        cfg_bus.cfg_high  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 16'd0, 16'd0, 5'b11011};
        tbl[1]  = '{1'b1, 1'b0, 16'd0, 16'd0, 5'b10011};
        tbl[2]  = '{1'b1, 1'b0, 16'd0, 16'd0, 5'b00111};
        tbl[3]  = '{1'b1, 1'b0, 16'd0, 16'd0, 5'b00011};
        tbl[4]  = '{1'b1, 1'b0, 16'd0, 16'd0, 5'b11011};
        tbl[5]  = '{1'b1, 1'b0, 16'd0, 16'd0, 5'b10011};
        tbl[6]  = '{1'b1, 1'b0, 16'd0, 16'd0, 5'b00111};
        tbl[7]  = '{1'b1, 1'b0, 16'd0, 16'd0, 5'b00011};
        tbl[8]  = '{1'b1, 1'b0, 16'd0, 16'd0, 5'b11011};
        tbl[9]  = '{1'b1, 1'b1, 16'd5, 16'd1, 5'b10010};
        tbl[10] = '{1'b1, 1'b0, 16'd0, 16'd0, 5'b00110};
        tbl[11] = '{1'b1, 1'b0, 16'd0, 16'd0, 5'b00010};
        tbl[12] = '{1'b1, 1'b0, 16'd0, 16'd0, 5'b11011};
        tbl[13] = '{1'b1, 1'b0, 16'd0, 16'd0, 5'b00111};
        tbl[14] = '{1'b1, 1'b0, 16'd0, 16'd0, 5'b00011};
        tbl[15] = '{1'b1, 1'b0, 16'd0, 16'd0, 5'b00011};
        tbl[16] = '{1'b1, 1'b0, 16'd0, 16'd0, 5'b00011};
        tbl[17] = '{1'b1, 1'b0, 16'd0, 16'd0, 5'b11011};
        tbl[18] = '{1'b1, 1'b0, 16'd0, 16'd0, 5'b00111};

        // Defaults then a mid-period reconfiguration to 5/1.
        do_reset();
        check("reset_state", 32'(dut_vec()), 32'(5'b00001));
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].en, tbl[i].valid, int'(tbl[i].div), int'(tbl[i].high));
            check($sformatf("vec%0d", i), 32'(dut_vec()), 32'(tbl[i].want));
        end

        // Illegal configs, including an accept that coincides with a wrap.
        do_reset();
        step(0, 1, 0, 0);
        check("illegal_accept_ready", 32'(cfg_bus.cfg_ready), 0);
        step(0, 0, 0, 0);
        check("idle_apply_ready", 32'(cfg_bus.cfg_ready), 1);
        pat6 = 6'b101010;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, 0);
            check($sformatf("div2_clk%0d", i), 32'(clk_out), 32'(pat6[5-i]));
        end
        step(1, 1, 3, 7);
        check("wrap_accept_clk", 32'(clk_out), 1);
        check("wrap_accept_ready", 32'(cfg_bus.cfg_ready), 0);
        pat7 = 7'b0110110;
        for (int i = 0; i < 7; i++) begin
            step(1, 0, 0, 0);
            check($sformatf("div3_clk%0d", i), 32'(clk_out), 32'(pat7[6-i]));
            if (i == 0) check("held_pending_ready", 32'(cfg_bus.cfg_ready), 0);
            if (i == 1) check("applied_ready", 32'(cfg_bus.cfg_ready), 1);
        end

        // en dropped with cnt=1, then a STOP->RUN resume.
        do_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("stop_fall", 32'({clk_out, fall_tick, busy}), 32'(3'b011));
        step(0, 0, 0, 0);
        check("stop_low2", 32'({clk_out, busy}), 32'(2'b01));
        step(0, 0, 0, 0);
        check("stop_idle", 32'({clk_out, busy}), 32'(2'b00));
        step(0, 0, 0, 0);
        check("idle_hold", 32'({clk_out, busy, rise_tick}), 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        check("resume_busy", 32'({clk_out, busy}), 32'(2'b01));
        step(1, 0, 0, 0);
        check("resume_rise", 32'({clk_out, rise_tick, busy}), 32'(3'b111));

        // Async reset mid-high phase with a pending config.
        do_reset();
        step(1, 0, 0, 0);
        step(1, 1, 7, 3);
        check("pre_rst_state", 32'({clk_out, cfg_bus.cfg_ready}), 32'(2'b10));
        #5;
        rst_n             = 1'b0;
        en                = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        #1;
        check("rst_async_out", 32'(dut_vec()), 32'(5'b00001));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        pat8 = 8'b11001100;
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 0);
            check($sformatf("post_rst_clk%0d", i), 32'(clk_out), 32'(pat8[7-i]));
        end
        check("post_rst_ready", 32'(cfg_bus.cfg_ready), 1);

        // Random traffic against the period model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit e, v;
            int d, h;
            e = ($urandom_range(0, 9) != 0);
            v = ($urandom_range(0, 3) == 0);
            d = int'($urandom_range(0, 9));
            h = int'($urandom_range(0, 10));
            step(e, v, d, h);
            check($sformatf("rand%0d", i), 32'(dut_vec()), 32'(model_vec()));
        end

`ifdef CLKDIV_PERIOD_CNT_EN
        do_reset();
        check("pcnt_reset", period_cnt, 0);
        repeat (40) step(1, 0, 0, 0);
        check("pcnt_ten", period_cnt, 10);
        force dut.period_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.period_cnt;
        step(1, 0, 0, 0);
        check("pcnt_hold", period_cnt, 32'hFFFF_FFFF);
        step(1, 0, 0, 0);
        check("pcnt_wrap", period_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
